// File: rtl/id_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage register scoreboard.
package id_scoreboard_pkg;

    localparam int SB_REG_ADDR_WIDTH = 5;
    localparam int SB_NUM_REGS       = 32;
    localparam int SB_CNT_WIDTH      = 2;
    localparam int SB_CNT_MAX        = (1 << SB_CNT_WIDTH) - 1;
    localparam bit SB_WB_BYPASS      = 1'b1;

    // Saturating 32-bit increment used by the stall statistics counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// ID/WB interlock bus between the pipeline (master) and the scoreboard (slave).
interface id_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    // Handshake: id_valid offers the ID instruction; it leaves ID in exactly the
    // cycle issue is high. stall holds it in IF/ID; flush drops it without issuing.
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_use_rs1;
    logic                      id_use_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    logic                      flush;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      stall;
    logic                      issue;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, flush, wb_reg_write, wb_rd,
        input  stall, issue
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, flush, wb_reg_write, wb_rd,
        output stall, issue
    );

endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with underflow flag.
module sb_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic dec_ok;
    logic do_inc;
    logic do_dec;

    // A retire against an empty counter is reported, never applied.
    assign underflow = dec & (cnt == '0);
    assign dec_ok    = dec & (cnt != '0);
    assign do_inc    = inc & !dec_ok & (cnt != CNT_MAX);
    assign do_dec    = dec_ok & !inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (do_inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end else if (do_dec) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Register-scoreboard interlock: tracks in-flight writes from ID issue to WB
// retire and stalls ID on a pending source or a full destination counter.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = SB_REG_ADDR_WIDTH,
    parameter int NUM_REGS       = SB_NUM_REGS,
    parameter int CNT_WIDTH      = SB_CNT_WIDTH,
    parameter bit WB_BYPASS      = SB_WB_BYPASS
) (
    input  logic                clk,
    input  logic                rst,
    id_scoreboard_if.slave      bus,
    output logic [NUM_REGS-1:0] busy,
    output logic [31:0]         stall_cycles,
    output logic                retire_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:1]  inc_vec;
    logic [NUM_REGS-1:1]  dec_vec;
    logic [NUM_REGS-1:1]  underflow_vec;

    logic ret;
    logic rs1_ready;
    logic rs2_ready;
    logic rs1_bypass;
    logic rs2_bypass;
    logic dest_full;
    logic stall_int;
    logic issue_int;

    assign ret = bus.wb_reg_write & (bus.wb_rd != '0);

    // Write-through register file: the last pending write retiring this cycle
    // is already visible to the reader.
    assign rs1_bypass = WB_BYPASS & (cnt[bus.id_rs1] == CNT_ONE) & ret & (bus.wb_rd == bus.id_rs1);
    assign rs2_bypass = WB_BYPASS & (cnt[bus.id_rs2] == CNT_ONE) & ret & (bus.wb_rd == bus.id_rs2);

    assign rs1_ready = !bus.id_use_rs1 | (bus.id_rs1 == '0) | (cnt[bus.id_rs1] == '0) | rs1_bypass;
    assign rs2_ready = !bus.id_use_rs2 | (bus.id_rs2 == '0) | (cnt[bus.id_rs2] == '0) | rs2_bypass;

    assign dest_full = bus.id_reg_write & (bus.id_rd != '0) & (cnt[bus.id_rd] == CNT_MAX)
                     & !(ret & (bus.wb_rd == bus.id_rd));

    // flush wins: a squashed instruction neither stalls nor reserves.
    assign stall_int = bus.id_valid & !bus.flush & (!rs1_ready | !rs2_ready | dest_full);
    assign issue_int = bus.id_valid & !bus.flush & !stall_int;

    assign bus.stall = stall_int;
    assign bus.issue = issue_int;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        assign inc_vec[i] = issue_int & bus.id_reg_write & (bus.id_rd == REG_ADDR_WIDTH'(i));
        assign dec_vec[i] = ret & (bus.wb_rd == REG_ADDR_WIDTH'(i));

        sb_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .cnt       (cnt[i]),
            .underflow (underflow_vec[i])
        );

        assign busy[i] = (cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            retire_err   <= 1'b0;
        end else begin
            if (stall_int) begin
                stall_cycles <= sat_inc32(stall_cycles);
            end
            if (|underflow_vec) begin
                retire_err <= 1'b1;
            end
        end
    end

endmodule
